vram_sram_model: RTL and testbench

- Behavioural responder for the external 8 KiB VRAM chip: the far end of the VRAM pin bus (MA[12:0], MD[7:0], active-low MCS/MOE/MWR) that the VRAM interface drives.
- Samples the pins on the simulation clock, commits writes at the trailing edge of the write strobe, and drives MD on reads after a modelled access time.
- Provides a backdoor load/dump port and sticky protocol-error flags for the bench.
- Sits at top level beside the DMG core, wired to the VRAM pads.

---
 rtl/vram_sram_model.sv | 166 ++++++++++++++++
 tb/tb_vram_sram_model.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vram_sram_model.sv
// rtl/vram_sram_model.sv - Behavioural responder for the external 8 KiB VRAM chip on the VRAM pin bus
//
// Ports:
//   clk, nreset                  sampling clock; asynchronous active-low reset
//   ma, md, mcs_n, moe_n, mwr_n  VRAM pin bus; md is driven only while a read is in progress
//   bd_req, bd_we, bd_addr,      backdoor load/dump request (req held until bd_ack)
//   bd_wdata, bd_rdata, bd_ack   backdoor data and one-cycle acknowledge
//   err_wr_addr, err_oe_wr       sticky protocol-error flags, cleared only by reset
//   wr_count                     saturating count of committed pin writes

module vram_sram_model #(
    parameter int AW         = 13,
    parameter int READ_LAT   = 2,
    parameter int MAX_WR_CNT = 65535
) (
    input  logic          clk,
    input  logic          nreset,
    input  logic [AW-1:0] ma,
    inout  wire  [7:0]    md,
    input  logic          mcs_n,
    input  logic          moe_n,
    input  logic          mwr_n,
    input  logic          bd_req,
    input  logic          bd_we,
    input  logic [AW-1:0] bd_addr,
    input  logic [7:0]    bd_wdata,
    output logic [7:0]    bd_rdata,
    output logic          bd_ack,
    output logic          err_wr_addr,
    output logic          err_oe_wr,
    output logic [15:0]   wr_count
);

    typedef enum logic [1:0] {ST_IDLE, ST_WRITE, ST_READ} state_t;

    state_t        state;
    logic [7:0]    mem [2**AW];

    logic [AW-1:0] s_ma;
    logic [7:0]    s_md;
    logic          s_mcs_n;
    logic          s_moe_n;
    logic          s_mwr_n;

    logic [AW-1:0] pend_addr;
    logic [7:0]    pend_data;
    logic [3:0]    lat_cnt;

    logic          strobe_act;
    logic          read_req;
    logic          bd_accept;
    logic          wr_commit;
    logic          mem_we;
    logic [AW-1:0] mem_waddr;
    logic [7:0]    mem_wdata;
    logic          md_oe;
    logic [7:0]    md_out;

    assign strobe_act = !s_mcs_n && !s_mwr_n;
    assign read_req   = !s_mcs_n && !s_moe_n;

    always_comb begin
        // A deselected chip in IDLE is the only window for the backdoor; the
        // !bd_ack term stops a still-held request being taken twice.
        bd_accept = (state == ST_IDLE) && s_mcs_n && bd_req && !bd_ack;
        // Trailing edge of the write strobe commits what was latched while it was active.
        wr_commit = (state == ST_WRITE) && !strobe_act;
        mem_we    = wr_commit || (bd_accept && bd_we);
        mem_waddr = wr_commit ? pend_addr : bd_addr;
        mem_wdata = wr_commit ? pend_data : bd_wdata;
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    // Raw pins gate the driver so MD lets go in the same cycle the interface
    // deselects, drops OE or starts driving for a write.
    assign md_oe  = (state == ST_READ) && !mcs_n && !moe_n && mwr_n;
    assign md_out = (lat_cnt == 4'(READ_LAT)) ? mem[s_ma] : 8'hxx;
    assign md     = md_oe ? md_out : 8'hzz;

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state       <= ST_IDLE;
            s_ma        <= '1;
            s_md        <= '1;
            s_mcs_n     <= 1'b1;
            s_moe_n     <= 1'b1;
            s_mwr_n     <= 1'b1;
            pend_addr   <= '0;
            pend_data   <= '0;
            lat_cnt     <= '0;
            bd_ack      <= 1'b0;
            bd_rdata    <= '0;
            err_wr_addr <= 1'b0;
            err_oe_wr   <= 1'b0;
            wr_count    <= '0;
        end else begin
            s_ma    <= ma;
            s_md    <= md;
            s_mcs_n <= mcs_n;
            s_moe_n <= moe_n;
            s_mwr_n <= mwr_n;

            bd_ack <= bd_accept;
            if (bd_accept && !bd_we) begin
                bd_rdata <= mem[bd_addr];
            end

            if (strobe_act && !s_moe_n) begin
                err_oe_wr <= 1'b1;
            end

            if (wr_commit && (wr_count != 16'(MAX_WR_CNT))) begin
                wr_count <= wr_count + 16'd1;
            end

            case (state)
                ST_IDLE: begin
                    if (strobe_act) begin
                        state     <= ST_WRITE;
                        pend_addr <= s_ma;
                        pend_data <= s_md;
                    end else if (read_req) begin
                        state   <= ST_READ;
                        lat_cnt <= '0;
                    end
                end
                ST_WRITE: begin
                    if (strobe_act) begin
                        // pend_addr still holds the previous active cycle's address.
                        if (s_ma != pend_addr) begin
                            err_wr_addr <= 1'b1;
                        end
                        pend_addr <= s_ma;
                        pend_data <= s_md;
                    end else if (read_req) begin
                        state   <= ST_READ;
                        lat_cnt <= '0;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                ST_READ: begin
                    if (strobe_act) begin
                        state     <= ST_WRITE;
                        pend_addr <= s_ma;
                        pend_data <= s_md;
                    end else if (mcs_n || moe_n) begin
                        state <= ST_IDLE;
                    end else if (ma != s_ma) begin
                        // s_ma takes a new address on this edge: restart the access time.
                        lat_cnt <= '0;
                    end else if (lat_cnt != 4'(READ_LAT)) begin
                        lat_cnt <= lat_cnt + 4'd1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_vram_sram_model.sv
// tb/tb_vram_sram_model.sv - Randomized scoreboard bench for vram_sram_model
module tb_vram_sram_model;

    localparam int AW        = 13;
    localparam int READ_LAT  = 2;
    localparam int TB_MAX_WR = 24;

    logic          clk      = 1'b0;
    logic          nreset   = 1'b0;
    logic [AW-1:0] ma       = '0;
    logic          mcs_n    = 1'b1;
    logic          moe_n    = 1'b1;
    logic          mwr_n    = 1'b1;
    logic          bd_req   = 1'b0;
    logic          bd_we    = 1'b0;
    logic [AW-1:0] bd_addr  = '0;
    logic [7:0]    bd_wdata = '0;
    logic [7:0]    bd_rdata;
    logic          bd_ack;
    logic          err_wr_addr;
    logic          err_oe_wr;
    logic [15:0]   wr_count;
    logic          tb_md_oe = 1'b0;
    logic [7:0]    tb_md    = '0;

    // Pulled-up bus: a released MD reads back as 8'hff.
    tri1 [7:0] md_bus;
    assign md_bus = tb_md_oe ? tb_md : 8'hzz;

    vram_sram_model #(
        .AW(AW), .READ_LAT(READ_LAT), .MAX_WR_CNT(TB_MAX_WR)
    ) dut (
        .clk(clk), .nreset(nreset), .ma(ma), .md(md_bus),
        .mcs_n(mcs_n), .moe_n(moe_n), .mwr_n(mwr_n),
        .bd_req(bd_req), .bd_we(bd_we), .bd_addr(bd_addr), .bd_wdata(bd_wdata),
        .bd_rdata(bd_rdata), .bd_ack(bd_ack),
        .err_wr_addr(err_wr_addr), .err_oe_wr(err_oe_wr), .wr_count(wr_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_wr   = 0;
    bit exp_err_wr = 1'b0;
    bit exp_err_oe = 1'b0;
    logic [7:0] ref_mem [int];
    int known_q[$];

    typedef struct { bit is_read; logic [7:0] data; } bd_exp_t;
    bd_exp_t bd_q[$];
    bd_exp_t mon_e;
    logic prev_ack = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_write(input int a, input logic [7:0] d);
        if (!ref_mem.exists(a)) known_q.push_back(a);
        ref_mem[a] = d;
    endfunction

    function automatic void model_count_write();
        if (exp_wr < TB_MAX_WR) exp_wr++;
    endfunction

    function automatic int pick_known();
        return known_q[$urandom_range(0, known_q.size() - 1)];
    endfunction

    task automatic check_status();
        chk("wr_count", wr_count, exp_wr);
        chk("err_wr_addr", err_wr_addr, exp_err_wr);
        chk("err_oe_wr", err_oe_wr, exp_err_oe);
    endtask

    // Scoreboard monitor: every acknowledge consumes one expected backdoor response.
    always @(negedge clk) begin
        if (nreset && bd_ack) begin
            chk("bd_ack_one_cycle", prev_ack, 1'b0);
            if (bd_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL bd_ack_unexpected: got ack with no request outstanding at %0t", $time);
            end else begin
                mon_e = bd_q.pop_front();
                if (mon_e.is_read) chk("bd_rdata", bd_rdata, mon_e.data);
            end
        end
        prev_ack = nreset ? bd_ack : 1'b0;
    end

    task automatic wait_ack(input int budget, output int n);
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!bd_ack && n < budget);
        chk("bd_ack_seen", bd_ack, 1'b1);
    endtask

    task automatic bd_op(input bit we, input int a, input logic [7:0] d, output int lat);
        bd_exp_t e;
        @(posedge clk); #1;
        bd_req = 1'b1; bd_we = we; bd_addr = AW'(a); bd_wdata = d;
        e.is_read = !we;
        e.data    = we ? 8'h00 : ref_mem[a];
        if (we) model_write(a, d);
        bd_q.push_back(e);
        wait_ack(16, lat);
        chk("bd_md_released", md_bus, 8'hff);
        @(posedge clk); #1;
        bd_req = 1'b0;
    endtask

    task automatic pin_write(input int a, input logic [7:0] d, input int len, input int a2, input int len2);
        @(posedge clk); #1;
        ma = AW'(a); tb_md = d; tb_md_oe = 1'b1; mcs_n = 1'b0; mwr_n = 1'b0; moe_n = 1'b1;
        repeat (len) @(posedge clk);
        if (len2 > 0) begin
            #1; ma = AW'(a2);
            repeat (len2) @(posedge clk);
        end
        #1; mwr_n = 1'b1; mcs_n = 1'b1; tb_md_oe = 1'b0;
        repeat (3) @(posedge clk);
        if (len2 > 0 && a2 != a) exp_err_wr = 1'b1;
        model_write((len2 > 0) ? a2 : a, d);
        model_count_write();
        @(negedge clk);
        check_status();
    endtask

    task automatic pin_oe_wr(input int a, input int len);
        @(posedge clk); #1;
        ma = AW'(a); tb_md_oe = 1'b0; mcs_n = 1'b0; mwr_n = 1'b0; moe_n = 1'b0;
        repeat (len) begin
            @(negedge clk);
            chk("oe_wr_md_released", md_bus, 8'hff);
            @(posedge clk);
        end
        #1; mwr_n = 1'b1; moe_n = 1'b1; mcs_n = 1'b1;
        repeat (3) @(posedge clk);
        exp_err_oe = 1'b1;
        model_write(a, 8'hff);
        model_count_write();
        @(negedge clk);
        check_status();
    endtask

    // Data appears once the pins have been sampled (1 edge), decoded into a read
    // (1 edge) and held for READ_LAT further edges; an address change restarts
    // only the READ_LAT part.
    task automatic pin_read(input int a, input int hold, input bit chg, input int a2);
        @(posedge clk); #1;
        ma = AW'(a); mcs_n = 1'b0; moe_n = 1'b0; mwr_n = 1'b1; tb_md_oe = 1'b0;
        for (int k = 1; k <= READ_LAT + 2 + hold; k++) begin
            @(negedge clk);
            if (k <= 2) chk("rd_decode_released", md_bus, 8'hff);
            else if (k >= READ_LAT + 3) chk("rd_data", md_bus, ref_mem[a]);
        end
        if (chg) begin
            @(posedge clk); #1;
            ma = AW'(a2);
            for (int k = 1; k <= READ_LAT + 3; k++) begin
                @(negedge clk);
                if (k == 1) chk("rd_data_before_change", md_bus, ref_mem[a]);
                else if (k >= READ_LAT + 2) chk("rd_data_new_addr", md_bus, ref_mem[a2]);
            end
        end
        @(posedge clk); #1;
        moe_n = 1'b1;
        #1;
        chk("rd_release_on_oe", md_bus, 8'hff);
        @(posedge clk); #1;
        mcs_n = 1'b1;
        repeat (2) @(posedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int op;
        int a;
        int a2;

        #1;
        chk("rst_bd_ack", bd_ack, 1'b0);
        chk("rst_bd_rdata", bd_rdata, 8'h00);
        chk("rst_md_released", md_bus, 8'hff);
        check_status();
        repeat (2) @(posedge clk);
        @(negedge clk);
        nreset = 1'b1;

        bd_op(1'b1, 'h1ABC, 8'h5A, lat);
        chk("bd_wr_ack_latency", lat, 1);
        bd_op(1'b0, 'h1ABC, 8'h00, lat);
        chk("bd_rd_ack_latency", lat, 1);
        bd_op(1'b1, 'h0124, 8'h96, lat);
        bd_op(1'b1, 'h0010, 8'h11, lat);

        pin_write('h0123, 8'hC3, 3, 0, 0);
        pin_read('h0123, 2, 1'b1, 'h0124);

        pin_write('h0010, 8'h3C, 2, 'h0011, 2);
        bd_op(1'b0, 'h0010, 8'h00, lat);
        bd_op(1'b0, 'h0011, 8'h00, lat);

        pin_oe_wr('h0200, 3);
        bd_op(1'b0, 'h0200, 8'h00, lat);

        // Backdoor request held off by an active pin read.
        @(posedge clk); #1;
        ma = AW'('h0123); mcs_n = 1'b0; moe_n = 1'b0; mwr_n = 1'b1;
        repeat (READ_LAT + 3) @(posedge clk);
        #1;
        bd_req = 1'b1; bd_we = 1'b0; bd_addr = AW'('h0123);
        bd_q.push_back('{1'b1, ref_mem['h0123]});
        repeat (6) begin
            @(negedge clk);
            chk("bd_blocked_by_read", bd_ack, 1'b0);
            chk("rd_data_while_bd_waits", md_bus, ref_mem['h0123]);
        end
        @(posedge clk); #1;
        mcs_n = 1'b1; moe_n = 1'b1;
        wait_ack(16, lat);
        @(posedge clk); #1;
        bd_req = 1'b0;

        for (int i = 0; i < 48; i++) begin
            op = $urandom_range(0, 3);
            a  = $urandom_range(0, 2**AW - 1);
            case (op)
                0: bd_op(1'b1, a, 8'($urandom_range(0, 255)), lat);
                1: bd_op(1'b0, pick_known(), 8'h00, lat);
                2: begin
                    if ($urandom_range(0, 3) == 0)
                        pin_write(a, 8'($urandom_range(0, 255)), $urandom_range(1, 3),
                                  $urandom_range(0, 2**AW - 1), $urandom_range(1, 2));
                    else
                        pin_write(a, 8'($urandom_range(0, 255)), $urandom_range(1, 3), 0, 0);
                end
                default: begin
                    a2 = pick_known();
                    pin_read(pick_known(), $urandom_range(1, 3), 1'($urandom_range(0, 1)), a2);
                end
            endcase
        end

        for (int i = 0; i < 30; i++) begin
            pin_write($urandom_range(0, 2**AW - 1), 8'($urandom_range(0, 255)), 1, 0, 0);
        end

        // Asynchronous reset in the middle of a read.
        a = pick_known();
        @(posedge clk); #1;
        ma = AW'(a); mcs_n = 1'b0; moe_n = 1'b0; mwr_n = 1'b1;
        repeat (READ_LAT + 3) @(posedge clk);
        @(negedge clk);
        chk("rd_data_before_reset", md_bus, ref_mem[a]);
        @(posedge clk); #3;
        nreset = 1'b0;
        #1;
        exp_wr = 0; exp_err_wr = 1'b0; exp_err_oe = 1'b0;
        chk("rst_async_md_released", md_bus, 8'hff);
        chk("rst_async_bd_ack", bd_ack, 1'b0);
        check_status();
        mcs_n = 1'b1; moe_n = 1'b1;
        @(negedge clk);
        nreset = 1'b1;
        repeat (2) @(posedge clk);
        bd_op(1'b0, 'h1ABC, 8'h00, lat);
        bd_op(1'b0, a, 8'h00, lat);
        for (int i = 0; i < 6; i++) bd_op(1'b0, pick_known(), 8'h00, lat);
        @(negedge clk);
        check_status();

        repeat (3) @(posedge clk);
        chk("bd_scoreboard_drained", bd_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
